// File: rtl/frame_lane_ctrl.sv
// Frame-level control and lane compositor: frame tick/counter, pause, per-frame
// button accumulator, and a registered lane-to-RGB output stage with aligned syncs.
module frame_lane_ctrl #(
    parameter int NUM_LANES  = 4,
    parameter int LANE_W     = 8,
    parameter int LANE_PX    = 160,
    parameter int ACC_W      = 4,
    parameter int SAT_MODE   = 0,
    parameter int TIME_SHIFT = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        visible_in,
    input  logic [9:0]                  px_x,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic                        btn_left,
    input  logic                        btn_right,
    input  logic                        btn_pause,
    input  logic [NUM_LANES*LANE_W-1:0] lane_data,
    output logic                        frame_tick,
    output logic [31:0]                 frame_cnt,
    output logic [7:0]                  anim_time,
    output logic [ACC_W-1:0]            btn_accum,
    output logic                        paused,
    output logic [3:0]                  vga_r,
    output logic [3:0]                  vga_g,
    output logic [3:0]                  vga_b,
    output logic                        hsync_out,
    output logic                        vsync_out
);

    localparam int AW = ACC_W + 4;
    localparam logic signed [AW-1:0] ACC_MAX = AW'((1 << ACC_W) - 1);

    // button bit order: 0 up, 1 down, 2 right, 3 left, 4 pause
    logic [4:0] btn_raw;
    logic [4:0] btn_meta;
    logic [4:0] btn_sync;
    logic       pause_prev;
    logic       vsync_prev;
    logic       vsync_armed;
    logic       paused_next;

    logic signed [AW-1:0] delta;
    logic signed [AW-1:0] acc_sum;
    logic [ACC_W-1:0]     accum_next;

    logic [31:0] px_ext;
    logic [7:0]  lane_byte;

    assign btn_raw   = {btn_pause, btn_left, btn_right, btn_down, btn_up};
    assign anim_time = frame_cnt[TIME_SHIFT+7:TIME_SHIFT];
    assign px_ext    = {22'd0, px_x};

    // A pause press landing on a tick already decides whether that tick counts.
    always_comb begin
        paused_next = paused ^ (btn_sync[4] & ~pause_prev);
    end

    always_comb begin
        delta = '0;
        if (btn_sync[0]) delta = delta + AW'(1);
        if (btn_sync[1]) delta = delta - AW'(1);
        if (btn_sync[2]) delta = delta + AW'(4);
        if (btn_sync[3]) delta = delta - AW'(4);
        acc_sum    = $signed({4'b0000, btn_accum}) + delta;
        accum_next = acc_sum[ACC_W-1:0];
        if (SAT_MODE != 0) begin
            if (acc_sum < 0)
                accum_next = '0;
            else if (acc_sum > ACC_MAX)
                accum_next = '1;
        end
    end

    // Comparator chain: the last lane boundary passed wins, so columns past the
    // final lane stay on the last lane.
    always_comb begin
        lane_byte = lane_data[LANE_W-8 +: 8];
        for (int k = 1; k < NUM_LANES; k++) begin
            if (px_ext >= $unsigned(k * LANE_PX))
                lane_byte = lane_data[k*LANE_W + LANE_W - 8 +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta    <= '0;
            btn_sync    <= '0;
            pause_prev  <= 1'b0;
            vsync_prev  <= 1'b0;
            vsync_armed <= 1'b0;
            frame_tick  <= 1'b0;
            frame_cnt   <= '0;
            btn_accum   <= '0;
            paused      <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
        end else begin
            btn_meta   <= btn_raw;
            btn_sync   <= btn_meta;
            pause_prev <= btn_sync[4];
            vsync_prev <= vsync_in;
            // vsync must be seen low after reset before an edge can count
            if (!vsync_in)
                vsync_armed <= 1'b1;
            frame_tick <= vsync_in & ~vsync_prev & vsync_armed;
            paused     <= paused_next;
            if (frame_tick) begin
                if (!paused_next)
                    frame_cnt <= frame_cnt + 32'd1;
                btn_accum <= accum_next;
            end
            if (visible_in) begin
                vga_g <= lane_byte[7:4];
                vga_r <= lane_byte[5:2];
                vga_b <= lane_byte[3:0];
            end else begin
                vga_g <= '0;
                vga_r <= '0;
                vga_b <= '0;
            end
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end

endmodule

// File: tb/tb_frame_lane_ctrl.sv
// Scoreboard bench for frame_lane_ctrl: wrap and saturate instances side by side.
module tb_frame_lane_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        visible_in = 1'b0;
    logic [9:0]  px_x = '0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_pause = 1'b0;
    logic [31:0] lane_data = 32'hF0C3_5A81;

    logic        tick_w, paused_w, hs_w, vs_w;
    logic [31:0] cnt_w;
    logic [7:0]  anim_w;
    logic [3:0]  acc_w, r_w, g_w, b_w;
    logic        tick_s, paused_s, hs_s, vs_s;
    logic [31:0] cnt_s;
    logic [7:0]  anim_s;
    logic [3:0]  acc_s, r_s, g_s, b_s;

    int n_cmp = 0;
    int n_err = 0;
    int acc_m_w = 0;
    int acc_m_s = 0;
    int ticks;
    int total;

    logic [3:0]  acc_q_w[$];
    logic [3:0]  acc_q_s[$];
    logic [12:0] pix_q[$];

    frame_lane_ctrl #(.SAT_MODE(0)) u_wrap (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .visible_in(visible_in), .px_x(px_x), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .btn_pause(btn_pause),
        .lane_data(lane_data), .frame_tick(tick_w), .frame_cnt(cnt_w),
        .anim_time(anim_w), .btn_accum(acc_w), .paused(paused_w),
        .vga_r(r_w), .vga_g(g_w), .vga_b(b_w), .hsync_out(hs_w), .vsync_out(vs_w)
    );

    frame_lane_ctrl #(.SAT_MODE(1)) u_sat (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .visible_in(visible_in), .px_x(px_x), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .btn_pause(btn_pause),
        .lane_data(lane_data), .frame_tick(tick_s), .frame_cnt(cnt_s),
        .anim_time(anim_s), .btn_accum(acc_s), .paused(paused_s),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .hsync_out(hs_s), .vsync_out(vs_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One vsync low/high cycle; counts frame_tick pulses in a bounded window.
    task automatic run_frame(output int nt);
        @(negedge clk) vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        vsync_in = 1'b1;
        nt = 0;
        repeat (6) begin
            @(negedge clk);
            if (tick_w) nt++;
        end
    endtask

    task automatic set_btns(input logic u, input logic d, input logic l, input logic r);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_pause();
        @(negedge clk) btn_pause = 1'b1;
        repeat (4) @(negedge clk);
        btn_pause = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Model the expected accumulators for the held buttons, then run a frame and score.
    task automatic accum_frame(input string tag);
        int d, nt;
        d = (btn_up ? 1 : 0) - (btn_down ? 1 : 0) + (btn_right ? 4 : 0) - (btn_left ? 4 : 0);
        acc_m_w = (((acc_m_w + d) % 16) + 16) % 16;
        acc_m_s = acc_m_s + d;
        if (acc_m_s < 0) acc_m_s = 0;
        if (acc_m_s > 15) acc_m_s = 15;
        acc_q_w.push_back(4'(acc_m_w));
        acc_q_s.push_back(4'(acc_m_s));
        run_frame(nt);
        chk({tag, "_ticks"}, 64'(nt), 64'd1);
        if (acc_q_w.size() > 0) chk({tag, "_wrap"}, 64'(acc_w), 64'(acc_q_w.pop_front()));
        if (acc_q_s.size() > 0) chk({tag, "_sat"}, 64'(acc_s), 64'(acc_q_s.pop_front()));
    endtask

    initial begin
        int px_tab[6];
        logic [7:0] byte_tab[6];
        logic [7:0] bv;
        logic [12:0] e;
        px_tab   = '{0, 159, 160, 479, 480, 639};
        byte_tab = '{8'h81, 8'h81, 8'h5A, 8'hC3, 8'hF0, 8'hF0};

        repeat (2) @(negedge clk);
        chk("rst_tick", 64'(tick_w), 64'd0);
        chk("rst_cnt", 64'(cnt_w), 64'd0);
        chk("rst_acc", 64'(acc_w), 64'd0);
        chk("rst_paused", 64'(paused_w), 64'd0);
        chk("rst_rgb", 64'({r_w, g_w, b_w, hs_w, vs_w}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            run_frame(ticks);
            chk("frame_tick_once", 64'(ticks), 64'd1);
        end
        chk("cnt3", 64'(cnt_w), 64'd3);
        total = 0;
        repeat (100) begin
            @(negedge clk);
            if (tick_w) total++;
        end
        chk("vsync_hold_no_tick", 64'(total), 64'd0);

        for (int i = 0; i < 61; i++) run_frame(ticks);
        chk("cnt64", 64'(cnt_w), 64'd64);
        chk("anim64", 64'(anim_w), 64'd2);

        press_pause();
        chk("paused_on", 64'(paused_w), 64'd1);
        total = 0;
        for (int i = 0; i < 10; i++) begin
            run_frame(ticks);
            total += ticks;
        end
        chk("paused_ticks", 64'(total), 64'd10);
        chk("paused_hold", 64'(cnt_w), 64'd64);
        press_pause();
        chk("paused_off", 64'(paused_w), 64'd0);
        run_frame(ticks);
        chk("cnt65", 64'(cnt_w), 64'd65);

        set_btns(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) accum_frame("right");
        set_btns(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) accum_frame("left");
        set_btns(1'b1, 1'b0, 1'b1, 1'b0);
        accum_frame("up_left");
        chk("up_left_13", 64'(acc_w), 64'd13);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            px_x = px_tab[i];
            visible_in = 1'b1;
            hsync_in = i[0];
            bv = byte_tab[i];
            pix_q.push_back({bv[5:2], bv[7:4], bv[3:0], i[0]});
            @(negedge clk);
            if (pix_q.size() > 0) begin
                e = pix_q.pop_front();
                chk($sformatf("pix_%0d", px_tab[i]), 64'({r_w, g_w, b_w, hs_w}), 64'(e));
            end
        end
        chk("vsync_out", 64'(vs_w), 64'd1);
        px_x = 10'd0;
        visible_in = 1'b0;
        pix_q.push_back('0);
        @(negedge clk);
        if (pix_q.size() > 0) chk("blank", 64'({r_w, g_w, b_w, 1'b0}), 64'(pix_q.pop_front()));
        chk("pix0_exact", 64'({g_w, r_w, b_w}), 64'h000);
        visible_in = 1'b1;
        @(negedge clk);
        chk("pix0_grb", 64'({g_w, r_w, b_w}), 64'h801);

        set_btns(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) accum_frame("down");
        set_btns(1'b0, 1'b0, 1'b0, 1'b0);
        press_pause();
        chk("pre_rst_acc9", 64'(acc_w), 64'd9);
        chk("pre_rst_paused", 64'(paused_w), 64'd1);

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_zero", 64'({tick_w, paused_w, acc_w, r_w, g_w, b_w, hs_w, vs_w}), 64'd0);
        chk("midrst_cnt", 64'(cnt_w), 64'd0);
        @(negedge clk) rst = 1'b0;
        total = 0;
        repeat (10) begin
            @(negedge clk);
            if (tick_w) total++;
        end
        chk("post_rst_no_tick", 64'(total), 64'd0);
        run_frame(ticks);
        chk("post_rst_tick", 64'(ticks), 64'd1);
        chk("post_rst_cnt", 64'(cnt_w), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
